// File: rtl/iq_stream_scheduler.sv
// Two-FIFO RX IQ scheduler: voice has priority with a burst limit for spectrum fairness,
// one sample is served per read request into held outputs, with a voice IRQ and overflow stats.
module iq_stream_scheduler #(
  parameter int unsigned VOICE_DEPTH = 8,
  parameter int unsigned SPEC_DEPTH  = 16,
  parameter int unsigned VOICE_BURST = 4,
  parameter int unsigned IRQ_LEVEL   = 2
) (
  input  logic                          clk_in,
  input  logic                          reset_n,
  input  logic [15:0]                   SPEC_I,
  input  logic [15:0]                   SPEC_Q,
  input  logic                          spec_valid,
  input  logic [15:0]                   VOICE_I,
  input  logic [15:0]                   VOICE_Q,
  input  logic                          voice_valid,
  input  logic                          rd_req,
  output logic [15:0]                   OUT_I,
  output logic [15:0]                   OUT_Q,
  output logic                          out_type,
  output logic                          out_empty,
  output logic                          out_valid,
  output logic                          irq_out,
  input  logic                          clr_stats,
  output logic [7:0]                    voice_ovf_cnt,
  output logic [7:0]                    spec_ovf_cnt,
  output logic [$clog2(VOICE_DEPTH):0]  voice_level,
  output logic [$clog2(SPEC_DEPTH):0]   spec_level
);

  localparam int unsigned VAW = $clog2(VOICE_DEPTH);
  localparam int unsigned SAW = $clog2(SPEC_DEPTH);
  localparam int unsigned BW  = $clog2(VOICE_BURST + 1);

  localparam logic [VAW:0]  V_FULL    = (VAW+1)'(VOICE_DEPTH);
  localparam logic [SAW:0]  S_FULL    = (SAW+1)'(SPEC_DEPTH);
  localparam logic [VAW:0]  IRQ_LVL   = (VAW+1)'(IRQ_LEVEL);
  localparam logic [BW-1:0] BURST_MAX = BW'(VOICE_BURST);

  logic [31:0]    v_mem_q [VOICE_DEPTH];
  logic [31:0]    s_mem_q [SPEC_DEPTH];
  logic [VAW-1:0] v_wp_q, v_rp_q;
  logic [SAW-1:0] s_wp_q, s_rp_q;
  logic [VAW:0]   v_cnt_q, v_cnt_d;
  logic [SAW:0]   s_cnt_q, s_cnt_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [7:0]     v_ovf_q, v_ovf_d, s_ovf_q, s_ovf_d;
  logic [15:0]    out_i_q, out_i_d, out_q_q, out_q_d;
  logic           out_type_q, out_type_d, out_empty_q, out_empty_d;
  logic           out_valid_q, irq_q;

  logic        v_empty, s_empty, v_full, s_full;
  logic        grant_v, grant_s, v_push, s_push, v_drop, s_drop;
  logic [31:0] v_head, s_head;

  assign v_empty = (v_cnt_q == '0);
  assign s_empty = (s_cnt_q == '0);
  assign v_full  = (v_cnt_q == V_FULL);
  assign s_full  = (s_cnt_q == S_FULL);
  assign v_head  = v_mem_q[v_rp_q];
  assign s_head  = s_mem_q[s_rp_q];

  // Grants use pre-push occupancy; a same-cycle pop frees a slot for a push into a full FIFO.
  assign grant_v = rd_req && !v_empty && (s_empty || (burst_q < BURST_MAX));
  assign grant_s = rd_req && !grant_v && !s_empty;
  assign v_push  = voice_valid && (!v_full || grant_v);
  assign s_push  = spec_valid  && (!s_full || grant_s);
  assign v_drop  = voice_valid && !v_push;
  assign s_drop  = spec_valid  && !s_push;

  always_comb begin
    v_cnt_d = v_cnt_q;
    if (v_push && !grant_v)      v_cnt_d = v_cnt_q + 1'b1;
    else if (!v_push && grant_v) v_cnt_d = v_cnt_q - 1'b1;

    s_cnt_d = s_cnt_q;
    if (s_push && !grant_s)      s_cnt_d = s_cnt_q + 1'b1;
    else if (!s_push && grant_s) s_cnt_d = s_cnt_q - 1'b1;

    burst_d = burst_q;
    if (grant_v && (burst_q != BURST_MAX)) burst_d = burst_q + 1'b1;
    else if (grant_s)                      burst_d = '0;
  end

  // An overflow in the same cycle as a clear leaves the count at 1.
  always_comb begin
    v_ovf_d = v_ovf_q;
    if (v_drop)         v_ovf_d = clr_stats ? 8'd1 : ((v_ovf_q == '1) ? v_ovf_q : v_ovf_q + 1'b1);
    else if (clr_stats) v_ovf_d = '0;

    s_ovf_d = s_ovf_q;
    if (s_drop)         s_ovf_d = clr_stats ? 8'd1 : ((s_ovf_q == '1) ? s_ovf_q : s_ovf_q + 1'b1);
    else if (clr_stats) s_ovf_d = '0;
  end

  always_comb begin
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    out_type_d  = out_type_q;
    out_empty_d = out_empty_q;
    if (grant_v) begin
      {out_i_d, out_q_d} = v_head;
      out_type_d         = 1'b1;
      out_empty_d        = 1'b0;
    end else if (grant_s) begin
      {out_i_d, out_q_d} = s_head;
      out_type_d         = 1'b0;
      out_empty_d        = 1'b0;
    end else if (rd_req) begin
      out_i_d     = '0;
      out_q_d     = '0;
      out_empty_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (v_push) v_mem_q[v_wp_q] <= {VOICE_I, VOICE_Q};
    if (s_push) s_mem_q[s_wp_q] <= {SPEC_I, SPEC_Q};
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      v_wp_q      <= '0;
      v_rp_q      <= '0;
      s_wp_q      <= '0;
      s_rp_q      <= '0;
      v_cnt_q     <= '0;
      s_cnt_q     <= '0;
      burst_q     <= '0;
      v_ovf_q     <= '0;
      s_ovf_q     <= '0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_type_q  <= 1'b0;
      out_empty_q <= 1'b1;
      out_valid_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (v_push)  v_wp_q <= v_wp_q + 1'b1;
      if (grant_v) v_rp_q <= v_rp_q + 1'b1;
      if (s_push)  s_wp_q <= s_wp_q + 1'b1;
      if (grant_s) s_rp_q <= s_rp_q + 1'b1;
      v_cnt_q     <= v_cnt_d;
      s_cnt_q     <= s_cnt_d;
      burst_q     <= burst_d;
      v_ovf_q     <= v_ovf_d;
      s_ovf_q     <= s_ovf_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_type_q  <= out_type_d;
      out_empty_q <= out_empty_d;
      out_valid_q <= rd_req;
      irq_q       <= (v_cnt_q >= IRQ_LVL);
    end
  end

  assign OUT_I         = out_i_q;
  assign OUT_Q         = out_q_q;
  assign out_type      = out_type_q;
  assign out_empty     = out_empty_q;
  assign out_valid     = out_valid_q;
  assign irq_out       = irq_q;
  assign voice_ovf_cnt = v_ovf_q;
  assign spec_ovf_cnt  = s_ovf_q;
  assign voice_level   = v_cnt_q;
  assign spec_level    = s_cnt_q;

endmodule
